draw_screen_bg: RTL
===================

# draw_screen_bg

Frame-synchronised screen-mode controller and background renderer. It sits between the VGA timing generator and the sprite/text overlay stages. It owns the MENU / GAME / PAUSE / GAME_OVER mode register and draws the matching background: screen edges, game arena frame, and the PLAY button box. Mode changes from buttons or mouse clicks are queued and committed only at the start of vertical blanking, so no frame is ever drawn half in one mode and half in another.

## Interface
Parameters:
- H_RES, 1024: active pixels per line.
- V_RES, 768: active lines.
- TOP_V_LINE, 317: arena inner top edge.
- BOTTOM_V_LINE, 617: arena inner bottom edge.
- LEFT_H_LINE, 361: arena inner left edge.
- RIGHT_H_LINE, 661: arena inner right edge.
- BORDER, 10: arena frame thickness in pixels.
- BTN_X, 384: PLAY box left edge.
- BTN_Y, 384: PLAY box top edge.
- BTN_W, 306: PLAY box width.
- BTN_H, 96: PLAY box height.
- BLINK_FRAMES, 16: frames per blink half-period; only used with BG_BLINK_EN.

Ports:
- pclk, input, 1: pixel clock; single clock domain.
- rst, input, 1: synchronous, active-high reset.
- hcount_in, vcount_in, input, 12 each: pixel position.
- hsync_in, vsync_in, hblnk_in, vblnk_in, input, 1 each: timing signals.
- game_on, menu_on, pause_on, game_over, input, 1 each: level mode requests from the board/game logic.
- xpos, ypos, input, 12 each: mouse position.
- mouse_left, input, 1: left mouse button level.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, output, matching widths: timing delayed by 1 cycle.
- rgb_out, output, 12: background colour.
- mode, output, 2: committed mode; MENU=00, GAME=01, PAUSE=10, GAME_OVER=11.
- play_selected, output, 1: high while mode==GAME.
- btn_hover, output, 1: mouse inside the PLAY box.

## Operation
- Hit test: hit = (xpos >= BTN_X) && (xpos < BTN_X+BTN_W) && (ypos >= BTN_Y) && (ypos < BTN_Y+BTN_H). Sums are computed at 13 bits, so there is no wrap.
- Click: mouse_left is registered. click = mouse_left & ~mouse_left_d, a single-cycle pulse per press. Held buttons never retrigger.
- Request arbitration, evaluated every cycle. The highest-priority valid request overwrites the pending register and sets pend_v:
  1. menu_on: request MENU from any mode.
  2. game_over: request GAME_OVER from GAME or PAUSE.
  3. pause_on: toggle GAME↔PAUSE. Edge-detected internally.
  4. game_on: request GAME from MENU or GAME_OVER.
  5. click: in MENU, a click inside the box requests GAME. In GAME_OVER, a click inside the box requests GAME and a click outside requests MENU. Clicks are ignored in GAME and PAUSE.
- Commit: on frame_start (vblnk_in & ~vblnk_d), if pend_v is set, mode takes pend and pend_v clears. A request arriving in the same cycle as frame_start is committed directly in that cycle.
- A request equal to the current mode is discarded and does not set pend_v.
- Rendering is based on the committed mode only, in this priority order:
  - Any blanking: black.
  - vcount==0: 0xFF0.
  - vcount==V_RES-1: 0xF00.
  - hcount==0: 0x0F0.
  - hcount==H_RES-1: 0x00F.
  - MENU: PLAY box is 0x0F0 when hovered, 0xFFF otherwise; rest 0x000.
  - GAME and PAUSE: arena frame (band of width BORDER outside the inner edges) is 0xFFF. Interior is 0x000 in GAME and 0x222 in PAUSE.
  - GAME_OVER: box is 0x039 when hovered, 0xFFF otherwise; background 0x192.

## Timing
- All outputs are registered. Pixel latency is 1 cycle: rgb_out for pixel (h,v) appears together with hcount_out==h.
- Commit latency: mode updates one cycle after frame_start. The first pixel rendered in the new mode is the first active pixel of the next frame.
- Reset: mode=MENU, pend_v=0, mouse_left_d=0, vblnk_d=0. All outputs are 0, except that mode encodes MENU (00).
- Reset asserted mid-frame discards any pending request.

## Configuration
- BG_BLINK_EN defined: a frame counter increments on frame_start and wraps at 2*BLINK_FRAMES-1. In GAME_OVER, while the counter is in its upper half, the non-hovered box is drawn as background colour 0x192, so the box blinks. The counter resets to 0 on rst and on every mode commit.
- BG_BLINK_EN undefined: no counter is built, and the box is always 0xFFF when not hovered.

## Structure
- Package/include draw_bg_pkg holds:
  - the mode codes MODE_MENU, MODE_GAME, MODE_PAUSE, MODE_OVER;
  - the colour constants listed above.
- Sub-module frame_sync: registers vblnk and produces frame_start. Under BG_BLINK_EN it also holds the frame counter and blink phase.

## Test plan
- Reset, then idle for 2 frames → mode=00, rgb_out=0xFFF at (400,400), rgb_out=0x000 at (100,300).
- MENU, mouse at (500,420), mouse_left held for 1000 cycles mid-frame → single click; mode stays 00 until the next vblank rising edge, becomes 01 one cycle later; play_selected=1.
- GAME: pulse pause_on → PAUSE at the next frame, interior (500,500)=0x222; pulse again → GAME.
- GAME with game_over and menu_on asserted in the same cycle → next commit gives MENU.
- GAME_OVER: click at (100,100) → MENU; click at (500,420) → GAME; each committed only at frame boundaries.
- BG_BLINK_EN, GAME_OVER, mouse outside the box → pixel (500,420) toggles between 0xFFF and 0x192 every 16 frames.

Source files
------------

// File: rtl/draw_bg_pkg.sv
// Shared mode codes and background colours for the screen-mode controller.
package draw_bg_pkg;

    localparam logic [1:0] MODE_MENU  = 2'b00;
    localparam logic [1:0] MODE_GAME  = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;
    localparam logic [1:0] MODE_OVER  = 2'b11;

    localparam logic [11:0] RGB_BLACK      = 12'h000;
    localparam logic [11:0] RGB_WHITE      = 12'hFFF;
    localparam logic [11:0] RGB_EDGE_TOP   = 12'hFF0;
    localparam logic [11:0] RGB_EDGE_BOT   = 12'hF00;
    localparam logic [11:0] RGB_EDGE_LEFT  = 12'h0F0;
    localparam logic [11:0] RGB_EDGE_RIGHT = 12'h00F;
    localparam logic [11:0] RGB_MENU_HOVER = 12'h0F0;
    localparam logic [11:0] RGB_PAUSE_BG   = 12'h222;
    localparam logic [11:0] RGB_OVER_HOVER = 12'h039;
    localparam logic [11:0] RGB_OVER_BG    = 12'h192;

endpackage

// File: rtl/draw_screen_bg_frame_sync.sv
// Frame-start detector on the rising edge of vblank; with BG_BLINK_EN it also
// keeps the frame counter that drives the GAME_OVER box blink.
module frame_sync #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic pclk,
    input  logic rst,
    input  logic vblnk,
    input  logic commit,
    output logic frame_start,
    output logic blink
);

    logic vblnk_d;

    always_ff @(posedge pclk) begin
        if (rst) vblnk_d <= 1'b0;
        else     vblnk_d <= vblnk;
    end

    assign frame_start = vblnk & ~vblnk_d;

`ifdef BG_BLINK_EN
    localparam int CW = $clog2(2 * BLINK_FRAMES);
    logic [CW-1:0] frame_cnt;

    // A mode commit restarts the blink so a fresh GAME_OVER always opens solid.
    always_ff @(posedge pclk) begin
        if (rst || commit)
            frame_cnt <= '0;
        else if (frame_start)
            frame_cnt <= (frame_cnt == CW'(2 * BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
    end

    assign blink = (frame_cnt >= CW'(BLINK_FRAMES));
`else
    logic unused_cfg;
    assign unused_cfg = commit ^ (BLINK_FRAMES == 0);
    assign blink      = 1'b0;
`endif

endmodule

// File: rtl/draw_screen_bg.sv
// Screen-mode register with frame-synchronised commits plus background renderer.
// Optional GAME_OVER box blink is enabled by defining BG_BLINK_EN.
module draw_screen_bg
    import draw_bg_pkg::*;
#(
    parameter int H_RES         = 1024,
    parameter int V_RES         = 768,
    parameter int TOP_V_LINE    = 317,
    parameter int BOTTOM_V_LINE = 617,
    parameter int LEFT_H_LINE   = 361,
    parameter int RIGHT_H_LINE  = 661,
    parameter int BORDER        = 10,
    parameter int BTN_X         = 384,
    parameter int BTN_Y         = 384,
    parameter int BTN_W         = 306,
    parameter int BTN_H         = 96,
    parameter int BLINK_FRAMES  = 16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic        game_on,
    input  logic        menu_on,
    input  logic        pause_on,
    input  logic        game_over,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [1:0]  mode,
    output logic        play_selected,
    output logic        btn_hover
);

    logic       mouse_left_d, pause_d;
    logic [1:0] pend, req_mode, mode_next;
    logic       pend_v, req_v, commit;
    logic       frame_start, blink;
    logic       hit, click, pause_edge;
    logic       in_box, in_outer, in_inner;
    logic [11:0] rgb_next;

    frame_sync #(.BLINK_FRAMES(BLINK_FRAMES)) u_frame_sync (
        .pclk        (pclk),
        .rst         (rst),
        .vblnk       (vblnk_in),
        .commit      (commit),
        .frame_start (frame_start),
        .blink       (blink)
    );

    // 13-bit compares so the box end never wraps.
    assign hit = ({1'b0, xpos} >= 13'(BTN_X)) && ({1'b0, xpos} < 13'(BTN_X + BTN_W)) &&
                 ({1'b0, ypos} >= 13'(BTN_Y)) && ({1'b0, ypos} < 13'(BTN_Y + BTN_H));
    assign click      = mouse_left & ~mouse_left_d;
    assign pause_edge = pause_on & ~pause_d;

    // Every branch requests a mode different from the committed one.
    always_comb begin
        req_v    = 1'b0;
        req_mode = mode;
        if (menu_on && mode != MODE_MENU) begin
            req_v = 1'b1; req_mode = MODE_MENU;
        end else if (game_over && (mode == MODE_GAME || mode == MODE_PAUSE)) begin
            req_v = 1'b1; req_mode = MODE_OVER;
        end else if (pause_edge && mode == MODE_GAME) begin
            req_v = 1'b1; req_mode = MODE_PAUSE;
        end else if (pause_edge && mode == MODE_PAUSE) begin
            req_v = 1'b1; req_mode = MODE_GAME;
        end else if (game_on && (mode == MODE_MENU || mode == MODE_OVER)) begin
            req_v = 1'b1; req_mode = MODE_GAME;
        end else if (click && mode == MODE_MENU && hit) begin
            req_v = 1'b1; req_mode = MODE_GAME;
        end else if (click && mode == MODE_OVER) begin
            req_v = 1'b1; req_mode = hit ? MODE_GAME : MODE_MENU;
        end
    end

    assign commit    = frame_start && (req_v || pend_v);
    assign mode_next = commit ? (req_v ? req_mode : pend) : mode;

    always_ff @(posedge pclk) begin
        if (rst) begin
            mode          <= MODE_MENU;
            pend          <= MODE_MENU;
            pend_v        <= 1'b0;
            mouse_left_d  <= 1'b0;
            pause_d       <= 1'b0;
            play_selected <= 1'b0;
        end else begin
            mode          <= mode_next;
            play_selected <= (mode_next == MODE_GAME);
            mouse_left_d  <= mouse_left;
            pause_d       <= pause_on;
            if (commit) begin
                pend_v <= 1'b0;
            end else if (req_v) begin
                pend   <= req_mode;
                pend_v <= 1'b1;
            end
        end
    end

    assign in_box   = (hcount_in >= 12'(BTN_X)) && ({1'b0, hcount_in} < 13'(BTN_X + BTN_W)) &&
                      (vcount_in >= 12'(BTN_Y)) && ({1'b0, vcount_in} < 13'(BTN_Y + BTN_H));
    assign in_outer = (hcount_in >= 12'(LEFT_H_LINE - BORDER)) && (hcount_in <= 12'(RIGHT_H_LINE + BORDER)) &&
                      (vcount_in >= 12'(TOP_V_LINE - BORDER))  && (vcount_in <= 12'(BOTTOM_V_LINE + BORDER));
    assign in_inner = (hcount_in >= 12'(LEFT_H_LINE)) && (hcount_in <= 12'(RIGHT_H_LINE)) &&
                      (vcount_in >= 12'(TOP_V_LINE))  && (vcount_in <= 12'(BOTTOM_V_LINE));

    always_comb begin
        rgb_next = RGB_BLACK;
        if (hblnk_in || vblnk_in)                rgb_next = RGB_BLACK;
        else if (vcount_in == 12'd0)             rgb_next = RGB_EDGE_TOP;
        else if (vcount_in == 12'(V_RES - 1))    rgb_next = RGB_EDGE_BOT;
        else if (hcount_in == 12'd0)             rgb_next = RGB_EDGE_LEFT;
        else if (hcount_in == 12'(H_RES - 1))    rgb_next = RGB_EDGE_RIGHT;
        else begin
            case (mode)
                MODE_MENU:  rgb_next = in_box ? (hit ? RGB_MENU_HOVER : RGB_WHITE) : RGB_BLACK;
                MODE_GAME:  rgb_next = (in_outer && !in_inner) ? RGB_WHITE : RGB_BLACK;
                MODE_PAUSE: rgb_next = (in_outer && !in_inner) ? RGB_WHITE :
                                       (in_inner ? RGB_PAUSE_BG : RGB_BLACK);
                default:    rgb_next = !in_box ? RGB_OVER_BG :
                                       (hit ? RGB_OVER_HOVER : (blink ? RGB_OVER_BG : RGB_WHITE));
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            btn_hover  <= 1'b0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_next;
            btn_hover  <= hit;
        end
    end

endmodule
